// File: rtl/wb_uart_pkg.sv
// Shared constants for the Wishbone UART slave: register map, STATUS layout, FSM encodings.
// Build option: WB_UART_RX_FIFO_EN selects a 4-entry RX FIFO instead of a single holding register.
package wb_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_RX_VALID   = 0;
    localparam int ST_TX_BUSY    = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_TX_OVF     = 4;

    localparam logic [15:0] MIN_DIV       = 16'd4;
    localparam int          RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/wb_uart_slave_rx.sv
// UART 8N1 deserializer: 2-flop synchronizer, start-glitch rejection, one-cycle byte/frame_err pulses.
module uart_rx_core
    import wb_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [15:0] div,
    output logic [7:0]  rx_byte,
    output logic        byte_valid,
    output logic        frame_err
);

    logic        sync1_reg, sync2_reg, prev_reg;
    logic        fall;
    rx_state_t   state_reg, state_next;
    logic [15:0] cnt_reg, div_reg;
    logic [2:0]  bit_reg;
    logic [7:0]  shift_reg;
    logic        half_tick, full_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= rx;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign fall      = prev_reg & ~sync2_reg;
    assign half_tick = (cnt_reg == {1'b0, div_reg[15:1]} - 16'd1);
    assign full_tick = (cnt_reg == div_reg - 16'd1);
    assign rx_byte   = shift_reg;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= RX_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RX_IDLE:  if (fall) state_next = RX_START;
            RX_START: if (half_tick) state_next = sync2_reg ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && bit_reg == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (full_tick) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (state_reg == RX_STOP && full_tick) begin
            byte_valid = sync2_reg;
            frame_err  = ~sync2_reg;
        end
    end

    // Divisor is captured on the start edge so a DIV write never disturbs a frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= 16'd0;
            div_reg   <= MIN_DIV;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            case (state_reg)
                RX_IDLE: begin
                    cnt_reg <= 16'd0;
                    bit_reg <= 3'd0;
                    if (fall) div_reg <= div;
                end
                RX_START: cnt_reg <= half_tick ? 16'd0 : cnt_reg + 16'd1;
                RX_DATA: begin
                    if (full_tick) begin
                        cnt_reg   <= 16'd0;
                        shift_reg <= {sync2_reg, shift_reg[7:1]};
                        bit_reg   <= bit_reg + 3'd1;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: cnt_reg <= full_tick ? 16'd0 : cnt_reg + 16'd1;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_slave.sv
// Wishbone-attached 8N1 UART: DATA/STATUS/DIV registers, TX serializer, RX via uart_rx_core.
// Build option: define WB_UART_RX_FIFO_EN for a 4-entry RX FIFO (default: single holding register).
module wb_uart_slave
    import wb_uart_pkg::*;
#(
    parameter logic [15:0] CLK_DIV     = 16'd434,
    parameter logic [3:0]  BASE_NIBBLE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] adr_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    input  logic        uart_rx,
    output logic        uart_tx
);

    logic        sel, acc, ack_reg;
    logic [1:0]  reg_idx;
    logic [15:0] dat_reg, rd_data, div_reg, status_word;
    logic        wr_data_acc, rd_data_acc, wr_status, wr_div;
    logic        unused_adr;

    assign reg_idx     = adr_i[1:0];
    assign sel         = cyc_i & stb_i & (adr_i[15:12] == BASE_NIBBLE);
    assign acc         = sel & ~ack_reg;
    assign wr_data_acc = acc & we_i & (reg_idx == REG_DATA);
    assign rd_data_acc = acc & ~we_i & (reg_idx == REG_DATA);
    assign wr_status   = acc & we_i & (reg_idx == REG_STATUS);
    assign wr_div      = acc & we_i & (reg_idx == REG_DIV);
    assign unused_adr  = ^adr_i[11:2];
    assign ack_o       = ack_reg;
    assign dat_o       = dat_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg <= 1'b0;
            dat_reg <= 16'h0000;
        end else begin
            ack_reg <= acc;
            dat_reg <= (acc & ~we_i) ? rd_data : 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         div_reg <= CLK_DIV;
        else if (wr_div) div_reg <= clamp_div(dat_i);
    end

    // ---------------- RX path ----------------
    logic [7:0] rx_byte, rx_head;
    logic       rx_byte_valid, rx_frame_err;
    logic       rx_valid, rx_full, rx_pop, rx_push;

    uart_rx_core u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx),
        .div        (div_reg),
        .rx_byte    (rx_byte),
        .byte_valid (rx_byte_valid),
        .frame_err  (rx_frame_err)
    );

    // A pop in the same cycle frees a slot, so the arriving byte is accepted, not an overrun.
    assign rx_pop  = rd_data_acc & rx_valid;
    assign rx_push = rx_byte_valid & (~rx_full | rx_pop);

`ifdef WB_UART_RX_FIFO_EN
    logic [7:0] fifo_mem [0:RX_FIFO_DEPTH-1];
    logic [1:0] wr_ptr_reg, rd_ptr_reg;
    logic [2:0] count_reg;

    always_ff @(posedge clk) begin
        if (rx_push) fifo_mem[wr_ptr_reg] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (rx_push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (rx_pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            count_reg <= count_reg + {2'b00, rx_push} - {2'b00, rx_pop};
        end
    end

    assign rx_valid = (count_reg != 3'd0);
    assign rx_full  = (count_reg == 3'(RX_FIFO_DEPTH));
    assign rx_head  = fifo_mem[rd_ptr_reg];
`else
    logic [7:0] hold_reg;
    logic       hold_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg       <= 8'h00;
            hold_valid_reg <= 1'b0;
        end else if (rx_push) begin
            hold_reg       <= rx_byte;
            hold_valid_reg <= 1'b1;
        end else if (rx_pop) begin
            hold_valid_reg <= 1'b0;
        end
    end

    assign rx_valid = hold_valid_reg;
    assign rx_full  = hold_valid_reg;
    assign rx_head  = hold_reg;
`endif

    // ---------------- TX path ----------------
    tx_state_t   tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg, tx_div_reg;
    logic [2:0]  tx_bit_reg;
    logic [7:0]  tx_shift_reg;
    logic        tx_tick, tx_busy, tx_start;

    assign tx_tick  = (tx_cnt_reg == tx_div_reg - 16'd1);
    assign tx_busy  = (tx_state_reg != TX_IDLE);
    assign tx_start = wr_data_acc & ~tx_busy;

    always_ff @(posedge clk) begin
        if (rst) tx_state_reg <= TX_IDLE;
        else     tx_state_reg <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_IDLE:  if (tx_start) tx_state_next = TX_START;
            TX_START: if (tx_tick) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        case (tx_state_reg)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift_reg[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt_reg   <= 16'd0;
            tx_div_reg   <= CLK_DIV;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'h00;
        end else if (tx_state_reg == TX_IDLE) begin
            tx_cnt_reg <= 16'd0;
            tx_bit_reg <= 3'd0;
            if (tx_start) begin
                tx_shift_reg <= dat_i[7:0];
                tx_div_reg   <= div_reg;
            end
        end else if (tx_tick) begin
            tx_cnt_reg <= 16'd0;
            if (tx_state_reg == TX_DATA) begin
                tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                tx_bit_reg   <= tx_bit_reg + 3'd1;
            end
        end else begin
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
        end
    end

    // ---------------- Sticky flags and read mux ----------------
    logic [2:0] sticky_set, sticky_reg;
    assign sticky_set = {wr_data_acc & tx_busy,
                         rx_frame_err,
                         rx_byte_valid & rx_full & ~rx_pop};

    // Bit gi of sticky_reg maps to STATUS bit ST_RX_OVERRUN+gi; a new event wins over a clear.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
            always_ff @(posedge clk) begin
                if (rst)                                     sticky_reg[gi] <= 1'b0;
                else if (sticky_set[gi])                     sticky_reg[gi] <= 1'b1;
                else if (wr_status && dat_i[ST_RX_OVERRUN + gi]) sticky_reg[gi] <= 1'b0;
            end
        end
    endgenerate

    assign status_word = {11'b0, sticky_reg, tx_busy, rx_valid};

    always_comb begin
        rd_data = 16'h0000;
        case (reg_idx)
            REG_DATA:   if (rx_valid) rd_data = {8'h00, rx_head};
            REG_STATUS: rd_data = status_word;
            REG_DIV:    rd_data = div_reg;
            REG_RSVD:   rd_data = 16'h0000;
            default:    rd_data = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_wb_uart_slave.sv
// Self-checking bench for wb_uart_slave: register map, TX framing, RX capture, flags, ack timing.
module tb_wb_uart_slave;

    localparam logic [15:0] A_DATA   = 16'hF000;
    localparam logic [15:0] A_STATUS = 16'hF001;
    localparam logic [15:0] A_DIV    = 16'hF002;
    localparam logic [15:0] A_RSVD   = 16'hF003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] adr_i = 16'h0, dat_i = 16'h0;
    logic [15:0] dat_o;
    logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
    logic        ack_o;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int checks = 0;
    int failures = 0;

    logic [15:0] rd_exp_q[$];
    logic [7:0]  rx_exp_q[$];
    logic        tx_bit_q[$];

    always #5 clk = ~clk;

    wb_uart_slave dut (
        .clk     (clk),
        .rst     (rst),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .we_i    (we_i),
        .stb_i   (stb_i),
        .cyc_i   (cyc_i),
        .ack_o   (ack_o),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] wdat,
                           output logic [15:0] rdat);
        int n;
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wdat;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack_o !== 1'b1 && n < 8);
        checks++;
        if (ack_o !== 1'b1) begin
            failures++;
            $display("FAIL wb_ack_timeout adr=%h got ack=%b exp ack=1", adr, ack_o);
            rdat = 16'hxxxx;
        end else begin
            rdat = dat_o;
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        $display("wb %s adr=%h wdat=%h rdat=%h", we ? "wr" : "rd", adr, wdat, rdat);
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (4) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        $display("serial rx byte=%h stop=%b", b, stop_bit);
    endtask

    task automatic test_reset;
        logic [15:0] r, e;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
        checks++;
        if (dat_o !== 16'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0000", dat_o); end
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        rd_exp_q.push_back(16'h01B2);
        wb_xfer(1'b0, A_DIV, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL reset_div got=%h exp=%h", r, e); end
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL reset_status got=%h exp=%h", r, e); end
    endtask

    task automatic test_div;
        logic [15:0] r, e;
        logic [15:0] wr_vals [3] = '{16'h0002, 16'h0010, 16'h0004};
        logic [15:0] rd_vals [3] = '{16'h0004, 16'h0010, 16'h0004};
        for (int i = 0; i < 3; i++) begin
            wb_xfer(1'b1, A_DIV, wr_vals[i], r);
            checks++;
            if (r !== 16'h0) begin failures++; $display("FAIL div_wr_dat got=%h exp=0000", r); end
            rd_exp_q.push_back(rd_vals[i]);
            wb_xfer(1'b0, A_DIV, 16'h0, r);
            e = rd_exp_q.pop_front(); checks++;
            if (r !== e) begin failures++; $display("FAIL div_read got=%h exp=%h", r, e); end
        end
        wb_xfer(1'b1, A_RSVD, 16'hFFFF, r);
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_RSVD, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL rsvd_read got=%h exp=%h", r, e); end
    endtask

    task automatic test_tx;
        logic [15:0] r, e;
        logic [7:0]  b;
        logic        eb;
        int n;
        b = 8'hA5;
        tx_bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_bit_q.push_back(b[i]);
        tx_bit_q.push_back(1'b1);
        wb_xfer(1'b1, A_DATA, 16'h00A5, r);
        n = 0;
        while (uart_tx !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("FAIL tx_start_timeout got=%b exp=0", uart_tx); end
        for (int bi = 0; bi < 10; bi++) begin
            eb = tx_bit_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (uart_tx !== eb) begin
                    failures++;
                    $display("FAIL tx_bit%0d_clk%0d got=%b exp=%b", bi, c, uart_tx, eb);
                end
                @(posedge clk); #1;
            end
        end
        $display("tx frame 0xA5 observed");
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL tx_idle_status got=%h exp=%h", r, e); end
    endtask

    task automatic test_tx_ovf;
        logic [15:0] r, e;
        wb_xfer(1'b1, A_DATA, 16'h00A5, r);
        wb_xfer(1'b1, A_DATA, 16'h0033, r);
        rd_exp_q.push_back(16'h0012);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL ovf_status got=%h exp=%h", r, e); end
        wb_xfer(1'b1, A_STATUS, 16'h0010, r);
        rd_exp_q.push_back(16'h0002);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL ovf_cleared got=%h exp=%h", r, e); end
        repeat (50) @(posedge clk);
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL ovf_done_status got=%h exp=%h", r, e); end
    endtask

    task automatic test_rx;
        logic [15:0] r, e;
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_DATA, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL rx_empty_read got=%h exp=%h", r, e); end
        rx_exp_q.push_back(8'h3C);
        send_serial(8'h3C, 1'b1);
        rd_exp_q.push_back(16'h0001);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL rx_status_valid got=%h exp=%h", r, e); end
        wb_xfer(1'b0, A_DATA, 16'h0, r);
        e = {8'h00, rx_exp_q.pop_front()}; checks++;
        if (r !== e) begin failures++; $display("FAIL rx_data got=%h exp=%h", r, e); end
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL rx_status_clear got=%h exp=%h", r, e); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] r, e;
        rx_exp_q.push_back(8'h11);
        send_serial(8'h11, 1'b1);
        rx_exp_q.push_back(8'h22);
        send_serial(8'h22, 1'b1);
`ifdef WB_UART_RX_FIFO_EN
        rd_exp_q.push_back(16'h0001);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL b2b_status got=%h exp=%h", r, e); end
        for (int i = 0; i < 2; i++) begin
            wb_xfer(1'b0, A_DATA, 16'h0, r);
            e = {8'h00, rx_exp_q.pop_front()}; checks++;
            if (r !== e) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, r, e); end
        end
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL b2b_status_end got=%h exp=%h", r, e); end
`else
        rd_exp_q.push_back(16'h0005);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL b2b_status got=%h exp=%h", r, e); end
        wb_xfer(1'b0, A_DATA, 16'h0, r);
        e = {8'h00, rx_exp_q.pop_front()}; checks++;
        if (r !== e) begin failures++; $display("FAIL b2b_data got=%h exp=%h", r, e); end
        void'(rx_exp_q.pop_front());
        rd_exp_q.push_back(16'h0004);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL b2b_overrun got=%h exp=%h", r, e); end
        wb_xfer(1'b1, A_STATUS, 16'h0004, r);
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL b2b_status_end got=%h exp=%h", r, e); end
`endif
    endtask

    task automatic test_frame_err;
        logic [15:0] r, e;
        send_serial(8'h55, 1'b0);
        rd_exp_q.push_back(16'h0008);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL frame_err_status got=%h exp=%h", r, e); end
        wb_xfer(1'b1, A_STATUS, 16'h0008, r);
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL frame_err_clear got=%h exp=%h", r, e); end
    endtask

    task automatic test_glitch;
        logic [15:0] r, e;
        @(posedge clk); #1 uart_rx = 1'b0;
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (12) @(posedge clk);
        $display("serial rx glitch 1 clk");
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL glitch_status got=%h exp=%h", r, e); end
    endtask

    task automatic test_ack_pattern;
        logic exp_ack [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 16'hF001;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_o !== exp_ack[i]) begin
                failures++;
                $display("FAIL ack_pattern%0d got=%b exp=%b", i, ack_o, exp_ack[i]);
            end
            @(posedge clk); #1;
        end
        stb_i = 1'b0; cyc_i = 1'b0;
        $display("wb held strobe adr=F001 4 cycles");
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = 16'h1001;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ack_o !== 1'b0 || dat_o !== 16'h0) begin
                failures++;
                $display("FAIL ack_unselected%0d got ack=%b dat=%h exp ack=0 dat=0000", i, ack_o, dat_o);
            end
            @(posedge clk); #1;
        end
        stb_i = 1'b0; cyc_i = 1'b0;
        $display("wb held strobe adr=1001 4 cycles");
    endtask

    task automatic test_reset_midframe;
        logic [15:0] r, e;
        wb_xfer(1'b1, A_DATA, 16'h0000, r);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        $display("reset asserted mid-frame");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (uart_tx !== 1'b1) begin failures++; $display("FAIL midframe_tx%0d got=%b exp=1", i, uart_tx); end
            @(posedge clk); #1;
        end
        rd_exp_q.push_back(16'h01B2);
        wb_xfer(1'b0, A_DIV, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL midframe_div got=%h exp=%h", r, e); end
        rd_exp_q.push_back(16'h0000);
        wb_xfer(1'b0, A_STATUS, 16'h0, r);
        e = rd_exp_q.pop_front(); checks++;
        if (r !== e) begin failures++; $display("FAIL midframe_status got=%h exp=%h", r, e); end
    endtask

    initial begin
        test_reset;
        test_div;
        test_tx;
        test_tx_ovf;
        test_rx;
        test_back_to_back;
        test_frame_err;
        test_glitch;
        test_ack_pattern;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
